// File: rtl/sysid_timer_slave.sv
// sysid_timer_slave: Avalon-MM system ID peripheral with scratch word, 64-bit uptime
// counter, coherent high-word snapshot, freeze/clear control and heartbeat output.
module sysid_timer_slave #(
   parameter logic [31:0] ID           = 32'h0000_0000,
   parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
   parameter int          PRESCALE     = 1,
   parameter int          READ_LATENCY = 1,
   parameter int          HB_BIT       = 24
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [2:0]  address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   input  logic [3:0]  byteenable,
   output logic [31:0] readdata,
   output logic        readdatavalid,
   output logic        heartbeat
);
   logic [31:0] scratch_q, scratch_d, shadow_q, shadow_d;
   logic [31:0] rdata_q, rdata_d, s1_data_q, s1_data_d, rd_mux;
   logic [63:0] uptime_q, uptime_d;
   logic [15:0] presc_q, presc_d;
   logic        freeze_q, freeze_d, rvalid_q, rvalid_d, s1_valid_q, s1_valid_d;
   logic        rd_acc, ctrl_wr, clear, tick;

   always_comb begin
      rd_acc  = read & ~write;
      ctrl_wr = write && address == 3'd3 && byteenable[0];
      clear   = ctrl_wr & writedata[1];
      tick    = !freeze_q && presc_q == 16'(PRESCALE - 1);
      case (address)
         3'd0:    rd_mux = ID;
         3'd1:    rd_mux = TIMESTAMP;
         3'd2:    rd_mux = scratch_q;
         3'd3:    rd_mux = {31'd0, freeze_q};
         3'd4:    rd_mux = uptime_q[31:0];
         3'd5:    rd_mux = shadow_q;
         3'd6:    rd_mux = 32'(PRESCALE);
         default: rd_mux = 32'd0;
      endcase
      scratch_d = scratch_q;
      for (int i = 0; i < 4; i++)
         if (write && address == 3'd2 && byteenable[i]) scratch_d[8*i +: 8] = writedata[8*i +: 8];
      freeze_d = ctrl_wr ? writedata[0] : freeze_q;
      // CLEAR wins over a same-cycle increment; freeze holds both counters
      presc_d  = clear ? 16'd0 : freeze_q ? presc_q : tick ? 16'd0 : presc_q + 16'd1;
      uptime_d = clear ? 64'd0 : tick ? uptime_q + 64'd1 : uptime_q;
      shadow_d = (rd_acc && address == 3'd4) ? uptime_q[63:32] : shadow_q;
      s1_valid_d = rd_acc;
      s1_data_d  = rd_acc ? rd_mux : s1_data_q;
      // Latency 2 drains through the s1 stage; latency 1 bypasses it
      rvalid_d = (READ_LATENCY == 2) ? s1_valid_q : rd_acc;
      rdata_d  = (READ_LATENCY == 2) ? (s1_valid_q ? s1_data_q : rdata_q)
                                     : (rd_acc ? rd_mux : rdata_q);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         scratch_q  <= '0;
         shadow_q   <= '0;
         uptime_q   <= '0;
         presc_q    <= '0;
         freeze_q   <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
      end else begin
         scratch_q  <= scratch_d;
         shadow_q   <= shadow_d;
         uptime_q   <= uptime_d;
         presc_q    <= presc_d;
         freeze_q   <= freeze_d;
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
      end
   end

   assign readdata      = rdata_q;
   assign readdatavalid = rvalid_q;
   assign heartbeat     = uptime_q[HB_BIT];
endmodule

// File: tb/tb_sysid_timer_slave.sv
// tb_sysid_timer_slave: two instances (latency 1 / prescale 1 and latency 2 / prescale 4)
// on a shared bus, checked against a cycle-count based reference model.
module tb_sysid_timer_slave;
   localparam logic [31:0] ID = 32'h5443_2132;
   localparam logic [31:0] TS = 32'h4D00_0000;

   logic        clock = 1'b0, reset_n = 1'b0;
   logic [2:0]  address = '0;
   logic        read = 1'b0, write = 1'b0;
   logic [31:0] writedata = '0;
   logic [3:0]  byteenable = '0;
   logic [31:0] rd1, rd2;
   logic        rdv1, rdv2, hb1, hb2;

   sysid_timer_slave #(.ID(ID), .TIMESTAMP(TS), .PRESCALE(1), .READ_LATENCY(1), .HB_BIT(2)) dut1 (
      .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
      .writedata(writedata), .byteenable(byteenable), .readdata(rd1), .readdatavalid(rdv1),
      .heartbeat(hb1));
   sysid_timer_slave #(.ID(ID), .TIMESTAMP(TS), .PRESCALE(4), .READ_LATENCY(2), .HB_BIT(5)) dut2 (
      .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
      .writedata(writedata), .byteenable(byteenable), .readdata(rd2), .readdatavalid(rdv2),
      .heartbeat(hb2));

   always #5 clock = ~clock;

   typedef struct { int due; logic [31:0] d; } ent_t;
   ent_t q1[$], q2[$];
   int tests = 0, fails = 0, n = 0;
   logic [31:0] m_scr, m_sh1, m_sh2, last1, last2, got1, got2;
   bit m_frz;
   longint unsigned m_base, m_run;

   // Uptime is simply the number of running cycles divided by the prescale
   function automatic longint unsigned upv(input int p);
      return m_base + m_run / longint'(p);
   endfunction

   function automatic logic [31:0] mrd(input int p, input logic [31:0] sh, input logic [2:0] a);
      longint unsigned u = upv(p);
      case (a)
         3'd0: return ID;
         3'd1: return TS;
         3'd2: return m_scr;
         3'd3: return {31'd0, m_frz};
         3'd4: return u[31:0];
         3'd5: return sh;
         3'd6: return p;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_scr = 0; m_sh1 = 0; m_sh2 = 0; m_frz = 0; m_base = 0; m_run = 0;
      last1 = 0; last2 = 0; q1.delete(); q2.delete();
   endtask

   task automatic cyc(input bit r, input bit w, input logic [2:0] a, input logic [31:0] wd,
                      input logic [3:0] be);
      ent_t e;
      longint unsigned u1, u2;
      address = a; read = r; write = w; writedata = wd; byteenable = be;
      if (r && !w) begin
         e.due = n;     e.d = mrd(1, m_sh1, a); q1.push_back(e);
         e.due = n + 1; e.d = mrd(4, m_sh2, a); q2.push_back(e);
         if (a == 3'd4) begin
            u1 = upv(1); u2 = upv(4);
            m_sh1 = u1[63:32]; m_sh2 = u2[63:32];
         end
      end
      if (!m_frz) m_run++;
      if (w && a == 3'd2)
         for (int i = 0; i < 4; i++) if (be[i]) m_scr[8*i +: 8] = wd[8*i +: 8];
      if (w && a == 3'd3 && be[0]) begin
         if (wd[1]) begin m_run = 0; m_base = 0; end
         m_frz = wd[0];
      end
      @(posedge clock); #1;
      read = 0; write = 0;
      tests++;
      if (q1.size() > 0 && q1[0].due == n) begin
         if (rdv1 !== 1'b1 || rd1 !== q1[0].d) begin
            fails++; $display("FAIL rd1 cyc %0d: got v=%b d=%h exp v=1 d=%h", n, rdv1, rd1, q1[0].d);
         end
         last1 = q1[0].d; void'(q1.pop_front());
      end else if (rdv1 !== 1'b0 || rd1 !== last1) begin
         fails++; $display("FAIL hold1 cyc %0d: got v=%b d=%h exp v=0 d=%h", n, rdv1, rd1, last1);
      end
      if (rdv1 === 1'b1) got1 = rd1;
      tests++;
      if (q2.size() > 0 && q2[0].due == n) begin
         if (rdv2 !== 1'b1 || rd2 !== q2[0].d) begin
            fails++; $display("FAIL rd2 cyc %0d: got v=%b d=%h exp v=1 d=%h", n, rdv2, rd2, q2[0].d);
         end
         last2 = q2[0].d; void'(q2.pop_front());
      end else if (rdv2 !== 1'b0 || rd2 !== last2) begin
         fails++; $display("FAIL hold2 cyc %0d: got v=%b d=%h exp v=0 d=%h", n, rdv2, rd2, last2);
      end
      if (rdv2 === 1'b1) got2 = rd2;
      u1 = upv(1); u2 = upv(4);
      tests++;
      if (hb1 !== u1[2] || hb2 !== u2[5]) begin
         fails++; $display("FAIL hb cyc %0d: got %b%b exp %b%b", n, hb1, hb2, u1[2], u2[5]);
      end
      n++;
   endtask

   task automatic test_reset();
      model_reset();
      repeat (3) @(posedge clock);
      @(negedge clock) reset_n = 1'b1;
      #1;
      tests++;
      if ({rd1, rdv1, hb1, rd2, rdv2, hb2} !== '0) begin
         fails++; $display("FAIL reset: got %h %b %b %h %b %b exp all 0", rd1, rdv1, hb1, rd2, rdv2, hb2);
      end
   endtask

   task automatic test_regmap();
      logic [31:0] exp1 [8] = '{ID, TS, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0};
      logic [31:0] exp2 [8] = '{ID, TS, 32'd0, 32'd0, 32'd0, 32'd0, 32'd4, 32'd0};
      for (int a = 0; a < 8; a++) begin
         cyc(1, 0, 3'(a), 0, 0);
         tests++;
         if (rdv1 !== 1'b1 || rdv2 !== 1'b0) begin
            fails++; $display("FAIL lat a%0d: got v1=%b v2=%b exp 1 0", a, rdv1, rdv2);
         end
         cyc(0, 0, 0, 0, 0);
         if (a != 4 && a != 5) begin
            tests++;
            if (got1 !== exp1[a] || got2 !== exp2[a]) begin
               fails++; $display("FAIL map a%0d: got %h %h exp %h %h", a, got1, got2, exp1[a], exp2[a]);
            end
         end
      end
   endtask

   task automatic test_scratch();
      cyc(0, 1, 2, 32'hA5A5_A5A5, 4'hF);
      cyc(0, 1, 2, 32'h1234_5678, 4'b0101);
      cyc(1, 0, 2, 0, 0); cyc(0, 0, 0, 0, 0);
      tests++;
      if (got1 !== 32'hA534_A578 || got2 !== 32'hA534_A578) begin
         fails++; $display("FAIL scratch: got %h %h exp a534a578", got1, got2);
      end
      cyc(0, 1, 1, 32'hDEAD_BEEF, 4'hF);
      cyc(1, 0, 1, 0, 0); cyc(0, 0, 0, 0, 0);
      tests++;
      if (got1 !== TS || got2 !== TS) begin
         fails++; $display("FAIL ro_ts: got %h %h exp %h", got1, got2, TS);
      end
   endtask

   task automatic test_uptime();
      logic [31:0] v;
      cyc(0, 1, 3, 32'h2, 4'h1);
      repeat (40) cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 3, 32'h1, 4'h1);
      cyc(1, 0, 4, 0, 0); cyc(0, 0, 0, 0, 0);
      v = got2;
      tests++;
      if (v < 9 || v > 11) begin
         fails++; $display("FAIL up40: got %0d exp 10+-1", v);
      end
      for (int k = 0; k < 2; k++) begin
         repeat (3) cyc(0, 0, 0, 0, 0);
         cyc(1, 0, 4, 0, 0); cyc(0, 0, 0, 0, 0);
         tests++;
         if (got2 !== v) begin
            fails++; $display("FAIL frozen: got %0d exp %0d", got2, v);
         end
      end
      cyc(0, 1, 3, 32'h2, 4'h1);
      cyc(1, 0, 4, 0, 0); cyc(0, 0, 0, 0, 0);
      tests++;
      if (got1 !== 0 || got2 !== 0) begin
         fails++; $display("FAIL clear: got %0d %0d exp 0 0", got1, got2);
      end
   endtask

   task automatic test_wrap();
      cyc(0, 1, 3, 32'h0, 4'h1);
      dut1.uptime_q = 64'h0000_0001_FFFF_FFFE; dut1.presc_q = 16'd0;
      dut2.uptime_q = 64'h0000_0001_FFFF_FFFE; dut2.presc_q = 16'd0;
      m_base = 64'h0000_0001_FFFF_FFFE; m_run = 0;
      cyc(1, 0, 4, 0, 0);
      cyc(1, 0, 5, 0, 0);
      cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
      tests++;
      if (got1 !== 32'd1 || got2 !== 32'd1) begin
         fails++; $display("FAIL shadow_hi: got %h %h exp 1 1", got1, got2);
      end
   endtask

   task automatic test_heartbeat();
      cyc(0, 1, 3, 32'h2, 4'h1);
      for (int i = 1; i <= 20; i++) begin
         cyc(0, 0, 0, 0, 0);
         tests++;
         if (hb1 !== 1'((i >> 2) & 1)) begin
            fails++; $display("FAIL hb_period %0d: got %b exp %b", i, hb1, 1'((i >> 2) & 1));
         end
      end
      cyc(0, 1, 3, 32'h1, 4'h1);
      repeat (6) begin
         cyc(0, 0, 0, 0, 0);
         tests++;
         if (hb1 !== 1'b1) begin
            fails++; $display("FAIL hb_freeze: got %b exp 1", hb1);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] wd;
      logic [2:0] a;
      for (int i = 0; i < 400; i++) begin
         a = 3'($urandom_range(0, 7));
         wd = $urandom;
         if (a == 3'd3 && $urandom_range(0, 7) != 0) wd[1] = 1'b0;
         cyc(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, a, wd, 4'($urandom_range(0, 15)));
      end
      repeat (3) cyc(0, 0, 0, 0, 0);
   endtask

   task automatic test_reset_inflight();
      cyc(0, 1, 3, 32'h0, 4'h1);
      repeat (3) cyc(1, 0, 0, 0, 0);
      #2 reset_n = 1'b0;
      #1;
      tests++;
      if (rdv1 !== 1'b0 || rdv2 !== 1'b0 || rd1 !== 0 || rd2 !== 0) begin
         fails++; $display("FAIL async_rst: got v=%b%b d=%h %h exp 0", rdv1, rdv2, rd1, rd2);
      end
      model_reset();
      repeat (3) @(posedge clock);
      @(negedge clock) reset_n = 1'b1;
      repeat (6) cyc(0, 0, 0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_regmap();
      test_scratch();
      test_uptime();
      test_wrap();
      test_heartbeat();
      test_random();
      test_reset_inflight();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
